dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Parametrised N-channel DMA request arbiter and DACK generator; successor to the fixed four-channel priority logic.
- Sits between the external DREQ pins and timing-and-control. It selects one winning channel, drives the HRQ/HLDA bus-hold handshake, and drives one-hot DACK from the assertDACK/deassertDACK strobes issued by timing-and-control.
- Supports fixed priority and rotating priority, selectable at run time.

Parameters:
- NUM_CH, 4, number of DMA channels; legal range 2..8.
- CH_W, $clog2(NUM_CH), width of the channel index (derived; do not override).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- dreq  input  NUM_CH  per-channel DMA request; active-high, level-sensitive.
- channelMask  input  NUM_CH  1 = channel masked (request ignored).
- rotatePriority  input  1  0 = fixed priority (channel 0 highest); 1 = rotating priority.
- hlda  input  1  hold acknowledge from the CPU.
- assertDACK  input  1  one-cycle strobe from timing-and-control.
- deassertDACK  input  1  one-cycle strobe from timing-and-control.
- hrq  output  1  hold request to the CPU.
- dack  output  NUM_CH  one-hot DMA acknowledge.
- activeChannel  output  CH_W  latched winning channel index.
- grantValid  output  1  high while a channel is latched (every state except SI).

Behaviour:
- Reset (asynchronous, while RESET=0):
  - state=SI; hrq=0; dack=0; activeChannel=0; grantValid=0; priority pointer topPrio=0.
  - Asserting reset mid-transfer clears all outputs immediately, with no wait for a clock edge.
- pending = dreq & ~channelMask (DREQ_SYNC_EN off: dreq used directly).
- Winner selection: scan pending starting at topPrio, increment mod NUM_CH; the first set bit wins.
  - Fixed mode: topPrio is forced to 0 for the scan; the stored pointer is untouched.
- FSM, all outputs registered:
  - SI: if pending != 0 → latch winner into activeChannel, hrq=1, grantValid=1, go S0. hrq is visible the cycle after pending is sampled.
  - S0 (waiting for HLDA):
    - If pending[activeChannel]=0 → hrq=0, grantValid=0, go SI. A new arbitration can start the following cycle.
    - Else if hlda=1 → go SA.
    - Otherwise hold.
  - SA (HLDA granted, waiting for strobe):
    - If hlda=0 → abort.
    - Else if assertDACK → dack[activeChannel]=1 next edge, go SD.
    - assertDACK and deassertDACK together in SA: assertDACK wins; deassertDACK is ignored.
  - SD (DACK active):
    - deassertDACK → dack=0, hrq=0, grantValid=0, go SI.
    - If rotatePriority=1, topPrio=(activeChannel+1) mod NUM_CH, so the served channel becomes lowest priority.
    - assertDACK in SD is ignored. dreq and mask changes in SD are ignored; the transfer completes.
  - Abort (hlda falls in SA or SD): dack=0, hrq=0, grantValid=0, go SI; topPrio is not updated.
- Invariants:
  - dack is always one-hot or zero.
  - dack is never nonzero unless hlda was sampled high in SA.
- Modulo wrap: with NUM_CH not a power of two, (activeChannel+1) wraps from NUM_CH-1 to 0.
- Mode switch: changing rotatePriority mid-transfer only affects the next scan.

Optional Feature:
- Macro: DMA_DREQ_SYNC_EN.
- Defined: each dreq bit passes through a two-flop synchronizer (flops reset to 0) before masking. This adds 2 cycles of latency: hrq asserts 3 cycles after dreq rises, and the S0 drop check uses the synchronized value.
- Undefined: dreq is used directly; hrq asserts 1 cycle after dreq rises.

Test Plan:
- Fixed priority: NUM_CH=4, rotatePriority=0, dreq=4'b1010, mask=0 → hrq=1 next cycle, activeChannel=1. Then hlda=1, assertDACK pulse → dack=4'b0010. deassertDACK → dack=0, hrq=0. Repeat → channel 1 wins again.
- Rotating priority: rotatePriority=1, dreq=4'b1111 held. Grants occur in order ch0, ch1, ch2, ch3, ch0. Run NUM_CH=3 → order 0, 1, 2, 0, exercising the wrap.
- Masking and drop: mask=4'b0001, dreq=4'b0001 → hrq stays 0. Then mask=0, dreq=0001, and drop dreq in S0 before hlda → hrq returns to 0 with dack never asserted.
- HLDA abort: in SD with dack=0010, drop hlda → dack=0, hrq=0 next edge. topPrio is unchanged, so ch1 wins the next round.
- Async reset: pull RESET low mid-SD between clock edges → dack, hrq, and grantValid go to 0 immediately. After release with dreq=0, outputs stay 0.
- DMA_DREQ_SYNC_EN defined: dreq[2] rises at cycle t → hrq=1 at cycle t+3, activeChannel=2. Undefined: hrq=1 at t+1.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// rtl/dma_priority_arbiter_if.sv - request/hold/acknowledge bundle for dma_priority_arbiter
// master = timing-and-control / pin side, slave = arbiter side.
interface dma_priority_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] dreq;
  logic [NUM_CH-1:0] channelMask;
  logic              rotatePriority;
  logic              hlda;
  logic              assertDACK;
  logic              deassertDACK;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic [CH_W-1:0]   activeChannel;
  logic              grantValid;

  modport master (
    output dreq, channelMask, rotatePriority, hlda, assertDACK, deassertDACK,
    input  hrq, dack, activeChannel, grantValid
  );

  modport slave (
    input  dreq, channelMask, rotatePriority, hlda, assertDACK, deassertDACK,
    output hrq, dack, activeChannel, grantValid
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - N-channel DMA request arbiter with HRQ/HLDA handshake and one-hot DACK
// Optional macro DMA_DREQ_SYNC_EN: two-flop synchronizer on dreq ahead of masking.
module dma_priority_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input logic                   CLK,
  input logic                   RESET,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {SI, S0, SA, SD} state_e;

  state_e            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic              gv_q, gv_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic [CH_W-1:0]   active_q, active_d;
  logic [CH_W-1:0]   top_q, top_d;

  logic [NUM_CH-1:0] dreq_s;
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   scan_start;
  logic [CH_W-1:0]   winner;

`ifdef DMA_DREQ_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.dreq;
      sync2_q <= sync1_q;
    end
  end

  assign dreq_s = sync2_q;
`else
  assign dreq_s = bus.dreq;
`endif

  assign pending    = dreq_s & ~bus.channelMask;
  assign scan_start = bus.rotatePriority ? top_q : '0;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

  // First pending channel found walking upward from start, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] p,
                                           input logic [CH_W-1:0]   start);
    logic            found;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] res;
    found = 1'b0;
    idx   = start;
    res   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && p[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = next_ch(idx);
    end
    return res;
  endfunction

  assign winner = pick(pending, scan_start);

  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    gv_d     = gv_q;
    dack_d   = dack_q;
    active_d = active_q;
    top_d    = top_q;
    unique case (state_q)
      SI: begin
        if (pending != '0) begin
          active_d = winner;
          hrq_d    = 1'b1;
          gv_d     = 1'b1;
          state_d  = S0;
        end
      end
      S0: begin
        if (!pending[active_q]) begin
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          state_d = SI;
        end else if (bus.hlda) begin
          state_d = SA;
        end
      end
      SA: begin
        if (!bus.hlda) begin
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          dack_d  = '0;
          state_d = SI;
        end else if (bus.assertDACK) begin
          dack_d           = '0;
          dack_d[active_q] = 1'b1;
          state_d          = SD;
        end
      end
      SD: begin
        // Losing HLDA is an abort: the served channel keeps its priority slot.
        if (!bus.hlda) begin
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          dack_d  = '0;
          state_d = SI;
        end else if (bus.deassertDACK) begin
          hrq_d   = 1'b0;
          gv_d    = 1'b0;
          dack_d  = '0;
          state_d = SI;
          if (bus.rotatePriority) begin
            top_d = next_ch(active_q);
          end
        end
      end
      default: begin
        state_d = SI;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= SI;
      hrq_q    <= 1'b0;
      gv_q     <= 1'b0;
      dack_q   <= '0;
      active_q <= '0;
      top_q    <= '0;
    end else begin
      state_q  <= state_d;
      hrq_q    <= hrq_d;
      gv_q     <= gv_d;
      dack_q   <= dack_d;
      active_q <= active_d;
      top_q    <= top_d;
    end
  end

  assign bus.hrq           = hrq_q;
  assign bus.grantValid    = gv_q;
  assign bus.dack          = dack_q;
  assign bus.activeChannel = active_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - randomized and directed bench for dma_priority_arbiter (4- and 3-channel instances)
module tb_dma_priority_arbiter;

`ifdef DMA_DREQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  dma_priority_arbiter_if #(.NUM_CH(4)) ifa ();
  dma_priority_arbiter_if #(.NUM_CH(3)) ifb ();

  dma_priority_arbiter #(.NUM_CH(4)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
  dma_priority_arbiter #(.NUM_CH(3)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));

  logic [7:0] dreq_v [2];
  logic [7:0] mask_v [2];
  logic       rot_v  [2];
  logic       hlda_v [2];
  logic       ad_v   [2];
  logic       dd_v   [2];
  logic [7:0] dack_o [2];
  logic [7:0] act_o  [2];
  logic       hrq_o  [2];
  logic       gv_o   [2];

  assign ifa.dreq = dreq_v[0][3:0];
  assign ifa.channelMask = mask_v[0][3:0];
  assign ifa.rotatePriority = rot_v[0];
  assign ifa.hlda = hlda_v[0];
  assign ifa.assertDACK = ad_v[0];
  assign ifa.deassertDACK = dd_v[0];
  assign ifb.dreq = dreq_v[1][2:0];
  assign ifb.channelMask = mask_v[1][2:0];
  assign ifb.rotatePriority = rot_v[1];
  assign ifb.hlda = hlda_v[1];
  assign ifb.assertDACK = ad_v[1];
  assign ifb.deassertDACK = dd_v[1];
  assign dack_o[0] = 8'(ifa.dack);
  assign dack_o[1] = 8'(ifb.dack);
  assign act_o[0] = 8'(ifa.activeChannel);
  assign act_o[1] = 8'(ifb.activeChannel);
  assign hrq_o[0] = ifa.hrq;
  assign hrq_o[1] = ifb.hrq;
  assign gv_o[0] = ifa.grantValid;
  assign gv_o[1] = ifb.grantValid;

  int n_checks = 0;
  int n_fail = 0;
  int mtop [2] = '{0, 0};
  int nch  [2] = '{4, 3};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first requesting channel at or after top, counting modulo n.
  function automatic int model_pick(input int n, input int pend, input int top);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (top + k) % n;
      if (((pend >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  task automatic idle_chk(input int w, input string tag);
    chk({tag, "_hrq"}, 32'(hrq_o[w]), 0);
    chk({tag, "_dack"}, 32'(dack_o[w]), 0);
    chk({tag, "_gv"}, 32'(gv_o[w]), 0);
  endtask

  task automatic xfer(input int w, input logic [7:0] rq, input logic rot,
                      input int exp_ch, input bit abort);
    dreq_v[w] = rq;
    rot_v[w] = rot;
    repeat (LAT) step();
    chk("grant_hrq", 32'(hrq_o[w]), 1);
    chk("grant_ch", 32'(act_o[w]), 32'(exp_ch));
    chk("grant_gv", 32'(gv_o[w]), 1);
    chk("grant_dack0", 32'(dack_o[w]), 0);
    hlda_v[w] = 1'b1;
    step();
    chk("sa_dack0", 32'(dack_o[w]), 0);
    chk("sa_hrq", 32'(hrq_o[w]), 1);
    ad_v[w] = 1'b1;
    dd_v[w] = 1'b1;
    dreq_v[w] = '0;
    step();
    dd_v[w] = 1'b0;
    chk("dack_onehot", 32'(dack_o[w]), 32'(1) << exp_ch);
    if (abort) hlda_v[w] = 1'b0;
    else dd_v[w] = 1'b1;
    step();
    ad_v[w] = 1'b0;
    dd_v[w] = 1'b0;
    hlda_v[w] = 1'b0;
    idle_chk(w, abort ? "abort" : "release");
    if (!abort && rot) mtop[w] = (exp_ch + 1) % nch[w];
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      dreq_v[w] = '0; mask_v[w] = '0; rot_v[w] = 1'b0;
      hlda_v[w] = 1'b0; ad_v[w] = 1'b0; dd_v[w] = 1'b0;
    end
    repeat (3) step();
    idle_chk(0, "reset");
    chk("reset_act", 32'(act_o[0]), 0);
    idle_chk(1, "reset_b");
    RESET = 1'b1;
    step();

    // Fixed priority: channel 1 beats 3, twice
    xfer(0, 8'b1010, 1'b0, 1, 1'b0);
    xfer(0, 8'b1010, 1'b0, 1, 1'b0);

    // Rotating priority over all four channels
    xfer(0, 8'b1111, 1'b1, 0, 1'b0);
    xfer(0, 8'b1111, 1'b1, 1, 1'b0);
    xfer(0, 8'b1111, 1'b1, 2, 1'b0);
    xfer(0, 8'b1111, 1'b1, 3, 1'b0);
    xfer(0, 8'b1111, 1'b1, 0, 1'b0);

    // Masked request is ignored, then a request dropped in S0
    rot_v[0] = 1'b0;
    mask_v[0] = 8'b0001;
    dreq_v[0] = 8'b0001;
    repeat (LAT + 2) step();
    idle_chk(0, "masked");
    dreq_v[0] = '0;
    repeat (LAT) step();
    mask_v[0] = '0;
    dreq_v[0] = 8'b0001;
    repeat (LAT) step();
    chk("drop_grant_hrq", 32'(hrq_o[0]), 1);
    chk("drop_grant_ch", 32'(act_o[0]), 0);
    dreq_v[0] = '0;
    repeat (LAT) step();
    idle_chk(0, "drop");

    // HLDA abort in SD leaves the pointer at channel 1
    xfer(0, 8'b1111, 1'b1, 1, 1'b1);
    xfer(0, 8'b1111, 1'b1, 1, 1'b0);

    // Three-channel wrap
    xfer(1, 8'b111, 1'b1, 0, 1'b0);
    xfer(1, 8'b111, 1'b1, 1, 1'b0);
    xfer(1, 8'b111, 1'b1, 2, 1'b0);
    xfer(1, 8'b111, 1'b1, 0, 1'b0);

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      logic       rot;
      logic [7:0] mk, rq;
      int         pend;
      rot = 1'($urandom_range(0, 1));
      mk = 8'($urandom_range(0, 15));
      rq = 8'($urandom_range(0, 15));
      pend = int'(rq & ~mk & 8'h0f);
      mask_v[0] = mk;
      if (pend == 0) begin
        rot_v[0] = rot;
        dreq_v[0] = rq;
        repeat (LAT + 1) step();
        chk("rand_nogrant_hrq", 32'(hrq_o[0]), 0);
        dreq_v[0] = '0;
        repeat (LAT) step();
      end else begin
        xfer(0, rq, rot, model_pick(4, pend, rot ? mtop[0] : 0), ($urandom_range(0, 3) == 0));
      end
    end
    mask_v[0] = '0;

    // Asynchronous reset between edges while in SD
    xfer(0, 8'b0100, 1'b0, 2, 1'b0);
    dreq_v[0] = 8'b0100;
    repeat (LAT) step();
    hlda_v[0] = 1'b1;
    step();
    ad_v[0] = 1'b1;
    dreq_v[0] = '0;
    step();
    ad_v[0] = 1'b0;
    chk("pre_reset_dack", 32'(dack_o[0]), 32'b0100);
    #3;
    RESET = 1'b0;
    #1;
    idle_chk(0, "async_reset");
    chk("async_reset_act", 32'(act_o[0]), 0);
    hlda_v[0] = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (LAT + 2) step();
    idle_chk(0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
